writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 12 +
 rtl/writeback_forward_lookup.sv | 28 ++
 rtl/writeback_queue.sv | 114 +++++++++++
 tb/tb_writeback_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared widths and the pending-write entry type for the writeback queue.
// These constants are the codebase's shared parameter set (word width, register-index width and queue depth).
package writeback_queue_pkg;
    localparam int WORD_WIDTH           = 32;
    localparam int REGISTER_INDEX_WIDTH = 5;
    localparam int WB_QUEUE_DEPTH       = 4;

    typedef struct packed {
        logic [REGISTER_INDEX_WIDTH-1:0] idx;
        logic [WORD_WIDTH-1:0]           data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_forward_lookup.sv
// Youngest-match search over the pending writes, presented oldest (slot 0) to youngest.
module writeback_forward_lookup
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WB_QUEUE_DEPTH
) (
    input  logic [REGISTER_INDEX_WIDTH-1:0] lookup_idx,
    input  logic [DEPTH-1:0]                entry_valid,
    input  wb_entry_t                       entries [DEPTH],
    output logic                            hit,
    output logic [WORD_WIDTH-1:0]           data
);

    // Later (younger) slots override earlier ones; index 0 never hits.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (lookup_idx != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (entry_valid[k] && entries[k].idx == lookup_idx) begin
                    hit  = 1'b1;
                    data = entries[k].data;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Circular writeback queue: merges memory-stage and ALU writes, drains one per cycle
// into the register file and forwards pending values to decode.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WB_QUEUE_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mem_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] mem_idx,
    input  logic [WORD_WIDTH-1:0]           mem_data,
    output logic                            mem_ready,
    input  logic                            alu_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] alu_idx,
    input  logic [WORD_WIDTH-1:0]           alu_data,
    output logic                            alu_ready,
    output logic                            rf_write_enable,
    output logic [REGISTER_INDEX_WIDTH-1:0] rf_write_idx,
    output logic [WORD_WIDTH-1:0]           rf_write_data,
    input  logic [REGISTER_INDEX_WIDTH-1:0] fwd_idx_1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] fwd_idx_2,
    output logic                            fwd_hit_1,
    output logic [WORD_WIDTH-1:0]           fwd_data_1,
    output logic                            fwd_hit_2,
    output logic [WORD_WIDTH-1:0]           fwd_data_2,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] free;
    logic             pop;
    logic             mem_take;
    logic             mem_push;
    logic             alu_push;

    wb_entry_t        entries [DEPTH];
    wb_entry_t        aged    [DEPTH];
    logic [DEPTH-1:0] aged_valid;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = !empty;

    // The unconditional pop frees the head slot this edge, so it counts as free space.
    assign free      = CNT_W'(DEPTH) - count + CNT_W'(pop);
    assign mem_take  = mem_valid && (mem_idx != '0);
    assign mem_ready = (free >= CNT_W'(1));
    assign alu_ready = (free >= (CNT_W'(1) + CNT_W'(mem_take)));

    // Index-0 writes are acknowledged but never stored.
    assign mem_push = mem_valid && mem_ready && (mem_idx != '0);
    assign alu_push = alu_valid && alu_ready && (alu_idx != '0);
    assign alu_slot = tail + PTR_W'(mem_push);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
            count <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
        end
    end

    // Entry payload is not reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            entries[tail] <= '{idx: mem_idx, data: mem_data};
        end
        if (alu_push) begin
            entries[alu_slot] <= '{idx: alu_idx, data: alu_data};
        end
    end

    assign rf_write_enable = !empty;
    assign rf_write_idx    = empty ? '0 : entries[head].idx;
    assign rf_write_data   = empty ? '0 : entries[head].data;

    // Re-order storage by age so the lookup can take the last match as the youngest.
    always_comb begin
        aged_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            aged[k]       = entries[head + PTR_W'(k)];
            aged_valid[k] = (CNT_W'(k) < count);
        end
    end

    writeback_forward_lookup #(.DEPTH(DEPTH)) u_lookup_1 (
        .lookup_idx  (fwd_idx_1),
        .entry_valid (aged_valid),
        .entries     (aged),
        .hit         (fwd_hit_1),
        .data        (fwd_data_1)
    );

    writeback_forward_lookup #(.DEPTH(DEPTH)) u_lookup_2 (
        .lookup_idx  (fwd_idx_2),
        .entry_valid (aged_valid),
        .entries     (aged),
        .hit         (fwd_hit_2),
        .data        (fwd_data_2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a scoreboard of expected register-file writes.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_idx, alu_idx;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_idx;
    logic [31:0] rf_write_data;
    logic [4:0]  fwd_idx_1, fwd_idx_2;
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;
    logic [2:0]  count;
    logic        full, empty;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_idx         (mem_idx),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .alu_valid       (alu_valid),
        .alu_idx         (alu_idx),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_idx    (rf_write_idx),
        .rf_write_data   (rf_write_data),
        .fwd_idx_1       (fwd_idx_1),
        .fwd_idx_2       (fwd_idx_2),
        .fwd_hit_1       (fwd_hit_1),
        .fwd_data_1      (fwd_data_1),
        .fwd_hit_2       (fwd_hit_2),
        .fwd_data_2      (fwd_data_2),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && rf_write_enable) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got idx %0d data %h, expected no write", rf_write_idx, rf_write_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("drain_idx", 32'(rf_write_idx), 32'(e.idx));
                chk("drain_data", rf_write_data, e.data);
            end
        end
    end

    task automatic set_in(input bit mv, input logic [4:0] mi, input logic [31:0] md,
                          input bit av, input logic [4:0] ai, input logic [31:0] ad);
        mem_valid = mv; mem_idx = mi; mem_data = md;
        alu_valid = av; alu_idx = ai; alu_data = ad;
    endtask

    // One cycle: check handshake mid-cycle, record what must be accepted, cross the edge.
    task automatic step(input bit exp_alu_rdy);
        @(negedge clk);
        chk("mem_ready", 32'(mem_ready), 32'd1);
        chk("alu_ready", 32'(alu_ready), 32'(exp_alu_rdy));
        if (mem_valid && mem_idx != 5'd0) sb.push_back({mem_idx, mem_data});
        if (alu_valid && exp_alu_rdy && alu_idx != 5'd0) sb.push_back({alu_idx, alu_data});
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (empty) begin
                done = 1'b1;
                break;
            end
            step(1'b1);
        end
        chk("drain_reaches_empty", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        fwd_idx_1 = 5'd0;
        fwd_idx_2 = 5'd0;
        #12;
        chk("rst_rf_we", 32'(rf_write_enable), 32'd0);
        chk("rst_rf_idx", 32'(rf_write_idx), 32'd0);
        chk("rst_rf_data", rf_write_data, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_fwd_hit_1", 32'(fwd_hit_1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single memory write
        set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        step(1'b1);
        chk("single_we", 32'(rf_write_enable), 32'd1);
        chk("single_idx", 32'(rf_write_idx), 32'd5);
        chk("single_data", rf_write_data, 32'hDEADBEEF);
        chk("single_count", 32'(count), 32'd1);
        step(1'b1);
        chk("single_empty_after", 32'(empty), 32'd1);

        // Same-cycle mem and alu to the same register: mem drains first, lookup sees alu
        fwd_idx_1 = 5'd3;
        fwd_idx_2 = 5'd7;
        set_in(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        step(1'b1);
        chk("pair_count", 32'(count), 32'd2);
        chk("pair_head_data", rf_write_data, 32'h11);
        chk("pair_fwd_hit", 32'(fwd_hit_1), 32'd1);
        chk("pair_fwd_data", fwd_data_1, 32'h22);
        chk("pair_fwd_miss_hit", 32'(fwd_hit_2), 32'd0);
        chk("pair_fwd_miss_data", fwd_data_2, 32'd0);
        step(1'b1);
        chk("pair_second_data", rf_write_data, 32'h22);
        chk("pair_fwd_head_data", fwd_data_1, 32'h22);
        step(1'b1);
        chk("pair_fwd_gone", 32'(fwd_hit_1), 32'd0);

        // Fill with two writes per cycle, then hold both valid while full
        set_in(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);  step(1'b1);
        chk("fill_count_1", 32'(count), 32'd2);
        set_in(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);  step(1'b1);
        chk("fill_count_2", 32'(count), 32'd3);
        set_in(1, 5'd5, 32'h105, 1, 5'd6, 32'h106);  step(1'b1);
        chk("fill_count_3", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        set_in(1, 5'd7, 32'h107, 1, 5'd20, 32'h120); step(1'b0);
        chk("fill_count_4", 32'(count), 32'd4);
        set_in(1, 5'd9, 32'h109, 1, 5'd20, 32'h120); step(1'b0);
        chk("fill_count_5", 32'(count), 32'd4);
        set_in(1, 5'd11, 32'h10B, 1, 5'd20, 32'h120); step(1'b0);
        chk("fill_count_6", 32'(count), 32'd4);
        drain();

        // Index-0 write is acknowledged and dropped
        fwd_idx_1 = 5'd0;
        set_in(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(1'b1);
        chk("zero_count", 32'(count), 32'd0);
        chk("zero_we", 32'(rf_write_enable), 32'd0);
        chk("zero_fwd_hit", 32'(fwd_hit_1), 32'd0);
        chk("zero_fwd_data", fwd_data_1, 32'd0);

        // Asynchronous reset mid-cycle with three pending writes
        set_in(1, 5'd12, 32'hC, 1, 5'd13, 32'hD);  step(1'b1);
        set_in(1, 5'd14, 32'hE, 1, 5'd15, 32'hF);  step(1'b1);
        fwd_idx_1 = 5'd13;
        #1;
        chk("prerst_count", 32'(count), 32'd3);
        chk("prerst_fwd_hit", 32'(fwd_hit_1), 32'd1);
        chk("prerst_fwd_data", fwd_data_1, 32'hD);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midrst_we", 32'(rf_write_enable), 32'd0);
        chk("midrst_data", rf_write_data, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_fwd_hit", 32'(fwd_hit_1), 32'd0);
        chk("midrst_fwd_data", fwd_data_1, 32'd0);
        chk("midrst_alu_ready", 32'(alu_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1);
        chk("postrst_empty", 32'(empty), 32'd1);
        step(1'b1);

        // Pointer wrap: ten single writes drain in order
        for (int i = 1; i <= 10; i++) begin
            set_in(1, 5'(i), 32'(i), 0, 0, 0);
            step(1'b1);
            chk("wrap_count", 32'(count), 32'd1);
        end
        drain();
        step(1'b1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
